// File: rtl/srf05_controller_pkg.sv
// rtl/srf05_controller_pkg.sv - shared types and constants for the SRF05 range controller
package srf05_controller_pkg;

    localparam int DIST_W     = 15;
    localparam int US_CNT_W   = 17;
    localparam int US_PER_SEC = 1_000_000;

    // Largest echo width that fits in the distance output.
    localparam logic [US_CNT_W-1:0] DIST_MAX = US_CNT_W'((1 << DIST_W) - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    // Clamp a microsecond count to the distance range before dropping the upper bits.
    function automatic logic [DIST_W-1:0] sat_dist(input logic [US_CNT_W-1:0] v);
        logic [DIST_W-1:0] r;
        if (v > DIST_MAX) begin
            r = {DIST_W{1'b1}};
        end else begin
            r = v[DIST_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/srf05_controller_us_tick_gen.sv
// rtl/srf05_controller_us_tick_gen.sv - restartable prescaler producing a one-cycle 1 us tick
module us_tick_gen
    import srf05_controller_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int DIV = CLK_FREQ_HZ / US_PER_SEC;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    // Count 0..DIV-1; a restart realigns the microsecond grid to the current cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/srf05_controller.sv
// rtl/srf05_controller.sv - SRF05 trigger/echo sequencer returning echo width in microseconds
module srf05_controller
    import srf05_controller_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 30000,
    parameter int HOLDOFF_US  = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              echo,
    output logic              trigger,
    output logic [DIST_W-1:0] distance,
    output logic              new_data,
    output logic              timeout,
    output logic              busy
);

    // Compare against limit-1 on a tick so each phase lasts exactly limit microseconds.
    localparam logic [US_CNT_W-1:0] TRIG_LAST    = US_CNT_W'(TRIG_US - 1);
    localparam logic [US_CNT_W-1:0] TIMEOUT_LAST = US_CNT_W'(TIMEOUT_US - 1);
    localparam logic [US_CNT_W-1:0] HOLDOFF_LAST = US_CNT_W'(HOLDOFF_US - 1);
    localparam logic [US_CNT_W-1:0] TIMEOUT_VAL  = US_CNT_W'(TIMEOUT_US);

    state_t              state;
    state_t              state_next;
    logic                state_chg;
    logic                tick;
    logic [US_CNT_W-1:0] us_cnt;

    logic echo_meta;
    logic echo_s;
    logic echo_prev;
    logic echo_rise;
    logic echo_fall;

    logic              load_dist;
    logic [DIST_W-1:0] dist_next;
    logic              nd_set;
    logic              to_set;

    logic trig_done;
    logic timeout_done;
    logic holdoff_done;

    // Two-flop synchronizer for the asynchronous echo pin, followed by registered edge pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_prev <= 1'b0;
            echo_rise <= 1'b0;
            echo_fall <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_prev <= echo_s;
            echo_rise <= echo_s & ~echo_prev;
            echo_fall <= ~echo_s & echo_prev;
        end
    end

    assign state_chg = (state_next != state);

    us_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .restart(state_chg),
        .tick   (tick)
    );

    // Microseconds spent in the current state; cleared on every transition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            us_cnt <= '0;
        end else if (state_chg) begin
            us_cnt <= '0;
        end else if (tick && (us_cnt != {US_CNT_W{1'b1}})) begin
            us_cnt <= us_cnt + 1'b1;
        end
    end

    assign trig_done    = tick && (us_cnt == TRIG_LAST);
    assign timeout_done = tick && (us_cnt == TIMEOUT_LAST);
    assign holdoff_done = tick && (us_cnt == HOLDOFF_LAST);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and measurement-event decode; aborts take priority, then echo edges, then timeouts.
    always_comb begin
        state_next = state;
        load_dist  = 1'b0;
        dist_next  = '0;
        nd_set     = 1'b0;
        to_set     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !echo_s) begin
                    state_next = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (!start) begin
                    state_next = ST_IDLE;
                end else if (trig_done) begin
                    state_next = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (!start) begin
                    state_next = ST_IDLE;
                end else if (echo_rise) begin
                    state_next = ST_MEASURE;
                end else if (timeout_done) begin
                    to_set     = 1'b1;
                    state_next = ST_HOLDOFF;
                end
            end
            ST_MEASURE: begin
                if (!start) begin
                    state_next = ST_IDLE;
                end else if (echo_fall) begin
                    load_dist  = 1'b1;
                    dist_next  = sat_dist(us_cnt);
                    nd_set     = 1'b1;
                    state_next = ST_HOLDOFF;
                end else if (timeout_done) begin
                    load_dist  = 1'b1;
                    dist_next  = sat_dist(TIMEOUT_VAL);
                    nd_set     = 1'b1;
                    to_set     = 1'b1;
                    state_next = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (holdoff_done) begin
                    state_next = start ? ST_TRIG : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs; trigger and busy track the state being entered so they switch with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trigger  <= 1'b0;
            busy     <= 1'b0;
            new_data <= 1'b0;
            timeout  <= 1'b0;
            distance <= '0;
        end else begin
            trigger  <= (state_next == ST_TRIG);
            busy     <= (state_next != ST_IDLE);
            new_data <= nd_set;
            timeout  <= to_set;
            if (load_dist) begin
                distance <= dist_next;
            end
        end
    end

endmodule

// File: doc/srf05_controller.md
Name: srf05_controller

Overview:
Drives one SRF05 ultrasonic range sensor and returns echo pulse width in microseconds. It is the sensor-side end of the start/reset/new_data/distance interface that the flight-control initialization and height-control logic consume. While `start` is high, the block runs repeating measurement cycles: trigger pulse, echo measurement, then a mandatory hold-off. Each completed measurement produces one `new_data` pulse alongside a stable `distance` value.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency; used to derive the 1 us tick.
- TRIG_US, 10, trigger pulse width in us.
- TIMEOUT_US, 30000, maximum wait for echo rise and maximum echo width, in us.
- HOLDOFF_US, 50000, idle time after a measurement ends before the next trigger, in us.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, level enable; measurements repeat while high.
- echo, in, 1, raw SRF05 echo pin (asynchronous).
- trigger, out, 1, SRF05 trigger pin.
- distance, out, 15, last valid echo width in us.
- new_data, out, 1, one-cycle pulse when `distance` updates.
- timeout, out, 1, one-cycle pulse on echo-rise timeout or echo-width timeout.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Reset drives the FSM to IDLE. Reset values: trigger=0, distance=0, new_data=0, timeout=0, busy=0; all counters=0; echo synchronizer=0.
- Echo is passed through a 2-FF synchronizer, then a registered edge detector (echo_s, echo_prev).
- us tick: a prescaler counts 0..CLK_FREQ_HZ/1e6-1 and emits a one-cycle tick at terminal count. The prescaler restarts at 0 on every FSM state change, so each state's us count is exact to ±1 us.
- us_cnt: 17 bits, cleared on state change, incremented on each tick.
- IDLE: move to TRIG when start=1 and echo_s=0. If echo_s=1, stay in IDLE.
- TRIG: trigger=1. Move to WAIT_RISE when us_cnt reaches TRIG_US (500 clocks at 50 MHz). Trigger falls in the same cycle as the transition.
- WAIT_RISE: on echo_s rising edge, move to MEASURE. If us_cnt reaches TIMEOUT_US first, pulse timeout, move to HOLDOFF, and leave distance unchanged.
- MEASURE: on echo_s falling edge, register distance = min(us_cnt, 32767) and pulse new_data in the next cycle, then move to HOLDOFF. If us_cnt reaches TIMEOUT_US first, register distance = TIMEOUT_US, pulse new_data and timeout together, and move to HOLDOFF.
- HOLDOFF: when us_cnt reaches HOLDOFF_US, go to TRIG if start=1, else go to IDLE.
- start falling in TRIG, WAIT_RISE, or MEASURE: abort to IDLE on the next clock. Trigger goes to 0 immediately, and no new_data or timeout pulse is produced.
- start falling in HOLDOFF: hold-off still completes, then the FSM goes to IDLE.
- distance holds its value between new_data pulses and through aborts. Only reset clears it.
- Echo edge and timeout in the same cycle: the edge wins.
- End-to-end latency: new_data asserts 3–4 clocks after the physical echo fall (synchronizer plus edge detect plus register).
- Arithmetic: unsigned throughout. Saturation happens before truncation to 15 bits.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=0, TRIG=1, WAIT_RISE=2, MEASURE=3, HOLDOFF=4 (3 bits).
  - DIST_W=15.
  - The US_PER_SEC constant.
- One natural sub-module: us_tick_gen, the prescaler with a synchronous restart input and a tick output. It is reusable by the IMU and motor blocks.

Test Plan:
1. start=1, echo held low: after the 2-FF sync settles, trigger goes high for exactly 500 clocks, then low. busy=1.
2. Echo high for 5800 us, starting 200 us after trigger falls: distance=5800±1, one new_data pulse, timeout=0. The next trigger rises 50000±1 us after echo falls.
3. No echo at all: timeout pulses once 30000 us after trigger falls, new_data=0, distance keeps its previous value.
4. Echo held high for 40 ms: at 30000 us into MEASURE, distance=30000 with new_data and timeout pulsing in the same cycle.
5. start dropped 1000 us into MEASURE: FSM reaches IDLE within 1 clock, trigger=0, no new_data. A later echo fall is ignored.
6. reset asserted mid-TRIG, asynchronously between clock edges: trigger=0 and busy=0 immediately. After release with start=1, a fresh 500-clock trigger pulse is produced.
